// File: rtl/peripheral_uart_rx_deserializer.sv
// UART rx front-end: rx synchroniser, 16x oversampled framer, FWFT byte FIFO on a valid/ready output (optional PERIPHERAL_UART_RX_TIMEOUT_EN).
// A byte is visible 1 cycle after its stop sample; a byte arriving at a full FIFO with no pop is dropped and flagged.

module peripheral_uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_vld,
  input  logic [WIDTH-1:0]           in_dat,
  output logic                       in_drop,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, pop, push;

  assign out_vld = (cnt_q != '0);
  assign out_dat = out_vld ? mem_q[rd_ptr_q] : '0;
  assign count   = cnt_q;

  always_comb begin
    full     = (cnt_q == CNT_W'(DEPTH));
    pop      = out_vld & out_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = in_vld & (~full | pop);
    in_drop  = in_vld & full & ~pop;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
    mem_q <= mem_d;
  end
endmodule

module peripheral_uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int SYNC_DEPTH = 3
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  input  logic [DIV_WIDTH-1:0]            cfg_div,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_parity_odd,
  input  logic                            rx_i,
  output logic [DATA_BITS-1:0]            rx_data_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
  output logic                            err_frame_o,
  output logic                            err_parity_o,
  output logic                            err_overrun_o,
  output logic                            event_o
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS-1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  rx_prev_q, rx_prev_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [3:0]            smp_cnt_q, smp_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  par_err_q, par_err_d;
  logic                  err_frame_q, err_frame_d;
  logic                  err_parity_q, err_parity_d;
  logic                  err_overrun_q;
  logic                  rx_s, fall, tick, bit_end, push_vld, push_drop;

  assign rx_s = sync_q[SYNC_DEPTH-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_DEPTH-2:0], rx_i};
    rx_prev_d = rx_s;
    fall      = rx_prev_q & ~rx_s;
    tick      = (div_cnt_q == '0);
    if (tick) div_cnt_d = (cfg_div == '0) ? '0 : cfg_div - DIV_WIDTH'(1);
    else      div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
    bit_end   = tick & (smp_cnt_q == 4'd15);
  end

  always_comb begin
    state_d      = state_q;
    smp_cnt_d    = tick ? smp_cnt_q + 4'd1 : smp_cnt_q;
    idx_d        = idx_q;
    data_d       = data_q;
    par_err_d    = par_err_q;
    push_vld     = 1'b0;
    err_frame_d  = 1'b0;
    err_parity_d = 1'b0;
    case (state_q)
      S_IDLE: if (fall) begin
        smp_cnt_d = '0;
        idx_d     = '0;
        par_err_d = 1'b0;
        state_d   = S_START;
      end
      S_START: if (tick && smp_cnt_q == 4'd7) begin
        if (rx_s) state_d = S_IDLE;
        else begin
          smp_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: if (bit_end) begin
        data_d[idx_q] = rx_s;
        idx_d         = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = cfg_parity_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (bit_end) begin
        par_err_d = ((^data_q) ^ cfg_parity_odd) != rx_s;
        state_d   = S_STOP;
      end
      S_STOP: if (bit_end) begin
        // Back to IDLE immediately so the next start edge half a bit later is seen.
        state_d = S_IDLE;
        if (!rx_s)          err_frame_d  = 1'b1;
        else if (par_err_q) err_parity_d = 1'b1;
        else                push_vld     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      sync_q        <= '1;
      rx_prev_q     <= 1'b1;
      div_cnt_q     <= '0;
      smp_cnt_q     <= '0;
      idx_q         <= '0;
      data_q        <= '0;
      par_err_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      rx_prev_q     <= rx_prev_d;
      div_cnt_q     <= div_cnt_d;
      smp_cnt_q     <= smp_cnt_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      par_err_q     <= par_err_d;
      err_frame_q   <= err_frame_d;
      err_parity_q  <= err_parity_d;
      err_overrun_q <= push_drop;
    end
  end

  peripheral_uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .in_vld  (push_vld),
    .in_dat  (data_q),
    .in_drop (push_drop),
    .out_vld (rx_valid_o),
    .out_rdy (rx_ready_i),
    .out_dat (rx_data_o),
    .count   (fifo_count_o)
  );

  assign err_frame_o   = err_frame_q;
  assign err_parity_o  = err_parity_q;
  assign err_overrun_o = err_overrun_q;

`ifdef PERIPHERAL_UART_RX_TIMEOUT_EN
  logic [9:0] to_cnt_q, to_cnt_d;
  logic       to_flag_q, to_flag_d;
  logic       pop;

  always_comb begin
    pop       = rx_valid_o & rx_ready_i;
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
    // 640 ticks = four 10-bit characters of idle line with data waiting.
    if (pop || (state_q == S_IDLE && fall)) to_cnt_d = '0;
    else if (tick && state_q == S_IDLE && rx_valid_o && to_cnt_q != 10'd640)
      to_cnt_d = to_cnt_q + 10'd1;
    if (pop)                        to_flag_d = 1'b0;
    else if (to_cnt_q == 10'd640)   to_flag_d = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign event_o = (fifo_count_o >= CNT_W'(FIFO_DEPTH/2)) | to_flag_q;
`else
  assign event_o = rx_valid_o;
`endif
endmodule

// File: tb/tb_peripheral_uart_rx_deserializer.sv
// Scoreboarded bench: frames are modelled at issue time, a monitor process consumes and compares.
`timescale 1ns/1ps
module tb_peripheral_uart_rx_deserializer;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_WIDTH  = 16;
  localparam int SYNC_DEPTH = 3;
  localparam int CNT_W      = $clog2(FIFO_DEPTH+1);

  logic                 HCLK = 1'b0;
  logic                 HRESET = 1'b1;
  logic [DIV_WIDTH-1:0] cfg_div = 16'd1;
  logic                 cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0;
  logic                 rx_i = 1'b1, rx_ready_i = 1'b0;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic [CNT_W-1:0]     fifo_count_o;
  logic                 err_frame_o, err_parity_o, err_overrun_o, event_o;

  peripheral_uart_rx_deserializer #(
    .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(DIV_WIDTH), .SYNC_DEPTH(SYNC_DEPTH)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_div(cfg_div), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .rx_i(rx_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .fifo_count_o(fifo_count_o), .err_frame_o(err_frame_o),
    .err_parity_o(err_parity_o), .err_overrun_o(err_overrun_o), .event_o(event_o)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0, passed = 0;
  logic [DATA_BITS-1:0] exp_q[$];
  int exp_frame = 0, exp_par = 0, exp_ovr = 0;
  int act_frame = 0, act_par = 0, act_ovr = 0;
  int ev_bad = 0, empty_bad = 0;
  int ready_mode = 0;  // 0: never pop, 1: random, 2: always

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Consumer and monitor: picks rx_ready_i for the coming edge, then scores any handshake.
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        rx_ready_i = 1'b0;
        continue;
      end
      case (ready_mode)
        0:       rx_ready_i = 1'b0;
        1:       rx_ready_i = ($urandom_range(0, 1) == 1);
        default: rx_ready_i = 1'b1;
      endcase
      if (err_frame_o === 1'b1)   act_frame++;
      if (err_parity_o === 1'b1)  act_par++;
      if (err_overrun_o === 1'b1) act_ovr++;
`ifndef PERIPHERAL_UART_RX_TIMEOUT_EN
      if (event_o !== rx_valid_o) ev_bad++;
`endif
      if (rx_valid_o !== 1'b1 && rx_data_o !== '0) empty_bad++;
      if (rx_valid_o === 1'b1 && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL pop_unexpected: got byte 0x%0h, expected none", rx_data_o);
        end else begin
          check("pop_data", rx_data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int cyc);
    rx_i = b;
    repeat (cyc) @(negedge HCLK);
  endtask

  // Reference model: parity bit makes the total count of ones even (or odd); outcome decided per frame.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit par_flip, input bit stop_bit, input int gap_bits);
    int bc;
    bit par_bit;
    bc      = 16 * ((cfg_div == '0) ? 1 : int'(cfg_div));
    par_bit = (($countones(d) % 2) == 1) ^ cfg_parity_odd;
    if (!stop_bit)                       exp_frame++;
    else if (cfg_parity_en && par_flip)  exp_par++;
    else if (exp_q.size() >= FIFO_DEPTH) exp_ovr++;
    else                                 exp_q.push_back(d);
    drive_bit(1'b0, bc);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i], bc);
    if (cfg_parity_en) drive_bit(par_bit ^ par_flip, bc);
    drive_bit(stop_bit, bc);
    drive_bit(1'b1, gap_bits * bc);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    ready_mode = 2;
    while ((exp_q.size() != 0 || rx_valid_o) && n < 3000) begin
      @(negedge HCLK);
      n++;
    end
    check({name, "_drain_timeout"}, (n >= 3000), 0);
    if (n >= 3000) exp_q.delete();
  endtask

  task automatic check_errs(input string name);
    check({name, "_err_frame"},   act_frame, exp_frame);
    check({name, "_err_parity"},  act_par,   exp_par);
    check({name, "_err_overrun"}, act_ovr,   exp_ovr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks so far", passed, checks);
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge HCLK);
    check("rst_valid", rx_valid_o, 0);
    check("rst_data", rx_data_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_err_frame", err_frame_o, 0);
    check("rst_err_parity", err_parity_o, 0);
    check("rst_err_overrun", err_overrun_o, 0);
    check("rst_event", event_o, 0);
    HRESET = 1'b0;
    drive_bit(1'b1, 20);

    // 8N1 0xA5, held in the FIFO
    ready_mode = 0;
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    check("t1_count", fifo_count_o, exp_q.size());
    check("t1_valid", rx_valid_o, 1);
    check("t1_data", rx_data_o, 8'hA5);
    check_errs("t1");
    wait_drain("t1");

    // even parity: correct then corrupted parity bit
    ready_mode = 0;
    cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b0;
    drive_bit(1'b1, 20);
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    send_frame(8'h3C, 1'b1, 1'b1, 1);
    check("t2_count", fifo_count_o, 1);
    check_errs("t2");
    wait_drain("t2");

    // framing error then a good frame
    ready_mode = 0;
    cfg_parity_en = 1'b0;
    drive_bit(1'b1, 20);
    send_frame(8'h55, 1'b0, 1'b0, 1);
    send_frame(8'h12, 1'b0, 1'b1, 1);
    check("t3_count", fifo_count_o, 1);
    check("t3_data", rx_data_o, 8'h12);
    check_errs("t3");
    wait_drain("t3");

    // false start glitch, then a normal frame must still be caught
    ready_mode = 0;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 60);
    check("t4_count_after_glitch", fifo_count_o, 0);
    check_errs("t4_glitch");
    send_frame(8'hC3, 1'b0, 1'b1, 1);
    wait_drain("t4");

    // nine back-to-back frames into an 8-deep FIFO
    ready_mode = 0;
    for (int k = 1; k <= 9; k++) send_frame(DATA_BITS'(k), 1'b0, 1'b1, 0);
    drive_bit(1'b1, 32);
    check("t5_count_full", fifo_count_o, FIFO_DEPTH);
    check_errs("t5");
    wait_drain("t5");

    // reset in the middle of a frame: nothing pushed, no errors
    ready_mode = 0;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 20);
    HRESET = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    drive_bit(1'b1, 200);
    check("t7_count_after_reset", fifo_count_o, 0);
    check("t7_valid_after_reset", rx_valid_o, 0);
    check_errs("t7");

    // randomized frames, divisors (0 acts as 1), parity modes and faults
    for (int f = 0; f < 24; f++) begin
      ready_mode = 1;
      cfg_div = DIV_WIDTH'($urandom_range(0, 3));
      cfg_parity_en = 1'($urandom_range(0, 1));
      cfg_parity_odd = 1'($urandom_range(0, 1));
      drive_bit(1'b1, 40);
      send_frame(DATA_BITS'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0),
                 int'($urandom_range(1, 2)));
    end
    wait_drain("rand");
    check_errs("rand");

`ifdef PERIPHERAL_UART_RX_TIMEOUT_EN
    ready_mode = 0;
    cfg_div = 16'd1;
    cfg_parity_en = 1'b0;
    drive_bit(1'b1, 40);
    send_frame(8'h77, 1'b0, 1'b1, 1);
    repeat (580) @(negedge HCLK);
    check("t6_event_before_timeout", event_o, 0);
    repeat (80) @(negedge HCLK);
    check("t6_event_after_timeout", event_o, 1);
    wait_drain("t6");
    repeat (2) @(negedge HCLK);
    check("t6_event_after_pop", event_o, 0);
`else
    check("event_tracks_valid_bad_cycles", ev_bad, 0);
`endif
    check("data_zero_when_empty_bad_cycles", empty_bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
